// File: rtl/jt6295_adpcm_mc.sv
// jt6295_adpcm_mc: time-multiplexed OKI ADPCM decoder core for CH voices.
// One shared decode datapath visits each voice in turn once per round and sums
// the attenuated predictors into a single mixed sample.
// Optional macro: JT6295_MC_SAT_EN clamps the mixed sum to the W-bit signed range.
module jt6295_adpcm_mc #(
  parameter int CH  = 4,
  parameter int W   = 12,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic [CH-1:0]         start,
  input  logic [CH-1:0]         stop,
  input  logic                  att_we,
  input  logic [CHW-1:0]        att_ch,
  input  logic [3:0]            att_din,
  output logic                  req,
  output logic [CHW-1:0]        req_ch,
  input  logic                  nib_ok,
  input  logic [3:0]            nib,
  output logic [CH-1:0]         active,
  output logic                  sample,
  output logic signed [W+2:0]   sound
);

  localparam int OW = W + 3;  // mixed output width
  localparam int DW = W + 4;  // unsigned delta width, holds 15 * max step
  localparam int PW = W + 5;  // signed working width for pred +/- delta
  localparam logic [CHW-1:0] LAST = CHW'(CH - 1);
  localparam logic signed [PW-1:0] PMAX = PW'((2 ** (W - 1)) - 1);
  localparam logic signed [PW-1:0] PMIN = PW'(-(2 ** (W - 1)));
`ifdef JT6295_MC_SAT_EN
  localparam logic signed [OW-1:0] OMAX = OW'((2 ** (W - 1)) - 1);
  localparam logic signed [OW-1:0] OMIN = OW'(-(2 ** (W - 1)));
`endif

  typedef enum logic [2:0] {IDLE, SLOT, REQ, CALC, NEXT, OUT} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   pred [CH];
  logic [5:0]            idx  [CH];
  logic [3:0]            att  [CH];
  logic [CH-1:0]         act;
  logic [CH-1:0]         pend_start;
  logic [CH-1:0]         pend_stop;
  logic [CHW-1:0]        slot;
  logic [3:0]            nib_q;
  logic signed [OW-1:0]  acc;
  logic signed [W-1:0]   new_pred;
  logic [5:0]            new_idx;
  logic signed [W-1:0]   new_contrib;

  // Standard 12-bit OKI step table, 49 entries.
  function automatic logic [10:0] step_base(input logic [5:0] i);
    logic [10:0] s;
    case (i)
      6'd0:  s = 11'd16;   6'd1:  s = 11'd17;   6'd2:  s = 11'd19;   6'd3:  s = 11'd21;
      6'd4:  s = 11'd23;   6'd5:  s = 11'd25;   6'd6:  s = 11'd28;   6'd7:  s = 11'd31;
      6'd8:  s = 11'd34;   6'd9:  s = 11'd37;   6'd10: s = 11'd41;   6'd11: s = 11'd45;
      6'd12: s = 11'd50;   6'd13: s = 11'd55;   6'd14: s = 11'd60;   6'd15: s = 11'd66;
      6'd16: s = 11'd73;   6'd17: s = 11'd80;   6'd18: s = 11'd88;   6'd19: s = 11'd97;
      6'd20: s = 11'd107;  6'd21: s = 11'd118;  6'd22: s = 11'd130;  6'd23: s = 11'd143;
      6'd24: s = 11'd157;  6'd25: s = 11'd173;  6'd26: s = 11'd190;  6'd27: s = 11'd209;
      6'd28: s = 11'd230;  6'd29: s = 11'd253;  6'd30: s = 11'd279;  6'd31: s = 11'd307;
      6'd32: s = 11'd337;  6'd33: s = 11'd371;  6'd34: s = 11'd408;  6'd35: s = 11'd449;
      6'd36: s = 11'd494;  6'd37: s = 11'd544;  6'd38: s = 11'd598;  6'd39: s = 11'd658;
      6'd40: s = 11'd724;  6'd41: s = 11'd796;  6'd42: s = 11'd876;  6'd43: s = 11'd963;
      6'd44: s = 11'd1060; 6'd45: s = 11'd1166; 6'd46: s = 11'd1282; 6'd47: s = 11'd1411;
      default: s = 11'd1552;
    endcase
    return s;
  endfunction

  // Step scaled up to the predictor width.
  function automatic logic [W-1:0] step_of(input logic [5:0] i);
    return W'(step_base(i)) << (W - 12);
  endfunction

  // Clamp a widened predictor back into the W-bit signed range.
  function automatic logic signed [W-1:0] sat_pred(input logic signed [PW-1:0] v);
    if (v > PMAX) return PMAX[W-1:0];
    if (v < PMIN) return PMIN[W-1:0];
    return v[W-1:0];
  endfunction

  // pred +/- ((2m+1) * step) >> 3, saturated.
  function automatic logic signed [W-1:0] next_pred(input logic signed [W-1:0] p,
                                                    input logic [5:0] i,
                                                    input logic [3:0] n);
    logic [DW-1:0]         d;
    logic signed [PW-1:0]  pe;
    logic signed [PW-1:0]  de;
    d  = (DW'({n[2:0], 1'b1}) * DW'(step_of(i))) >> 3;
    pe = {{(PW - W){p[W-1]}}, p};
    de = $signed({1'b0, d});
    return sat_pred(n[3] ? (pe - de) : (pe + de));
  endfunction

  // Magnitudes 0..3 step down by one, 4..7 step up by 2/4/6/8; clamped to 0..48.
  function automatic logic [5:0] next_idx(input logic [5:0] i, input logic [2:0] m);
    logic signed [7:0] t;
    t = $signed({2'b00, i});
    if (m[2]) t = t + $signed({5'b00000, m[1:0], 1'b0}) + 8'sd2;
    else      t = t - 8'sd1;
    if (t < 8'sd0)  return 6'd0;
    if (t > 8'sd48) return 6'd48;
    return t[5:0];
  endfunction

  // Attenuated voice contribution; large shifts collapse to the sign.
  function automatic logic signed [W-1:0] contrib(input logic signed [W-1:0] p,
                                                  input logic [3:0] a);
    if (int'(a) >= W) return {W{p[W-1]}};
    return p >>> a;
  endfunction

  // Final output stage: optional clamp of the mixed sum.
  function automatic logic signed [OW-1:0] mix_out(input logic signed [OW-1:0] v);
`ifdef JT6295_MC_SAT_EN
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
`else
    return v;
`endif
  endfunction

  assign active = act;

  // Decode arithmetic for the voice currently in slot.
  always_comb begin
    new_pred    = next_pred(pred[slot], idx[slot], nib_q);
    new_idx     = next_idx(idx[slot], nib_q[2:0]);
    new_contrib = contrib(new_pred, att[slot]);
  end

  // Round sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Round sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cen) state_d = SLOT;
      SLOT:    state_d = act[slot] ? REQ : NEXT;
      REQ:     if (nib_ok) state_d = CALC;
      CALC:    state_d = NEXT;
      NEXT:    state_d = (slot == LAST) ? OUT : SLOT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Voice state, pending masks, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < CH; v++) begin
        pred[v] <= '0;
        idx[v]  <= '0;
        att[v]  <= '0;
      end
      act        <= '0;
      pend_start <= '0;
      pend_stop  <= '0;
      slot       <= '0;
      nib_q      <= '0;
      acc        <= '0;
      req        <= 1'b0;
      req_ch     <= '0;
      sample     <= 1'b0;
      sound      <= '0;
    end else begin
      sample     <= 1'b0;
      pend_start <= pend_start | start;
      pend_stop  <= pend_stop | stop;
      if (att_we) att[att_ch] <= att_din;
      // req is high exactly while the sequencer sits in REQ
      req <= (state_d == REQ);
      if (state_d == REQ) req_ch <= slot;
      case (state_q)
        IDLE: begin
          if (cen) begin
            // start wins over stop for the same voice in the same round
            for (int v = 0; v < CH; v++) begin
              if (pend_start[v] || start[v]) begin
                act[v]  <= 1'b1;
                pred[v] <= '0;
                idx[v]  <= '0;
              end else if (pend_stop[v] || stop[v]) begin
                act[v] <= 1'b0;
              end
            end
            pend_start <= '0;
            pend_stop  <= '0;
            slot       <= '0;
            acc        <= '0;
          end
        end
        REQ: begin
          if (nib_ok) nib_q <= nib;
        end
        CALC: begin
          pred[slot] <= new_pred;
          idx[slot]  <= new_idx;
          acc        <= acc + $signed({{3{new_contrib[W-1]}}, new_contrib});
        end
        NEXT: begin
          if (slot != LAST) slot <= slot + 1'b1;
        end
        OUT: begin
          sound  <= mix_out(acc);
          sample <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_adpcm_mc.sv
// Self-checking bench for jt6295_adpcm_mc with an arithmetic reference model.
`timescale 1ns/1ps
module tb_jt6295_adpcm_mc;

  localparam int CH  = 4;
  localparam int W   = 12;
  localparam int CHW = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cen = 1'b0;
  logic [CH-1:0]       start = '0;
  logic [CH-1:0]       stop = '0;
  logic                att_we = 1'b0;
  logic [CHW-1:0]      att_ch = '0;
  logic [3:0]          att_din = '0;
  logic                req;
  logic [CHW-1:0]      req_ch;
  logic                nib_ok = 1'b1;
  logic [3:0]          nib = '0;
  logic [CH-1:0]       active;
  logic                sample;
  logic signed [W+2:0] sound;

  int checks = 0;
  int failures = 0;

  // reference model state
  int        m_pred [CH];
  int        m_idx  [CH];
  int        m_att  [CH];
  bit [CH-1:0] m_act, m_pstart, m_pstop;
  int        nib_tab [CH];
  int        step_tab [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60,
                               66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209,
                               230, 253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658,
                               724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};

  jt6295_adpcm_mc #(.CH(CH), .W(W), .CHW(CHW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .stop(stop),
    .att_we(att_we), .att_ch(att_ch), .att_din(att_din),
    .req(req), .req_ch(req_ch), .nib_ok(nib_ok), .nib(nib),
    .active(active), .sample(sample), .sound(sound)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int v = 0; v < CH; v++) begin
      m_pred[v] = 0; m_idx[v] = 0; m_att[v] = 0;
    end
    m_act = '0; m_pstart = '0; m_pstop = '0;
  endfunction

  function automatic void model_round_start();
    for (int v = 0; v < CH; v++) begin
      if (m_pstart[v]) begin
        m_act[v] = 1'b1; m_pred[v] = 0; m_idx[v] = 0;
      end else if (m_pstop[v]) begin
        m_act[v] = 1'b0;
      end
    end
    m_pstart = '0; m_pstop = '0;
  endfunction

  function automatic void model_voice(input int v, input int n);
    int m, st, d, hi, lo;
    m  = n % 8;
    st = step_tab[m_idx[v]] * (1 << (W - 12));
    d  = ((2 * m + 1) * st) / 8;
    m_pred[v] = (n >= 8) ? m_pred[v] - d : m_pred[v] + d;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    if (m_pred[v] > hi) m_pred[v] = hi;
    if (m_pred[v] < lo) m_pred[v] = lo;
    m_idx[v] = m_idx[v] + ((m < 4) ? -1 : 2 * (m - 3));
    if (m_idx[v] < 0)  m_idx[v] = 0;
    if (m_idx[v] > 48) m_idx[v] = 48;
  endfunction

  function automatic int model_contrib(input int v);
    if (m_att[v] >= W) return (m_pred[v] < 0) ? -1 : 0;
    return m_pred[v] >>> m_att[v];
  endfunction

  function automatic int model_mix();
    int s;
    s = 0;
    for (int v = 0; v < CH; v++) if (m_act[v]) s += model_contrib(v);
`ifdef JT6295_MC_SAT_EN
    if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
    if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
`endif
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; cen = 1'b0; start = '0; stop = '0; att_we = 1'b0; nib_ok = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic pulse(input logic [CH-1:0] s, input logic [CH-1:0] p);
    start = s; stop = p;
    @(posedge clk); #1;
    start = '0; stop = '0;
    m_pstart |= s; m_pstop |= p;
  endtask

  task automatic set_att(input int v, input int a);
    att_we = 1'b1; att_ch = CHW'(v); att_din = 4'(a);
    @(posedge clk); #1;
    att_we = 1'b0;
    m_att[v] = a;
  endtask

  // One full round with nib_ok high; checks latency, request order, active and sound.
  task automatic do_round(input string tag);
    int n, lat, ord_o, ord_e, exp_lat;
    bit got;
    model_round_start();
    exp_lat = 2; ord_e = 0;
    for (int v = 0; v < CH; v++) begin
      if (m_act[v]) begin exp_lat += 4; ord_e = ord_e * 8 + v + 1; end
      else exp_lat += 2;
    end
    cen = 1'b1; n = 0; got = 1'b0; ord_o = 0; lat = -1;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      cen = 1'b0;
      if (req) begin
        ord_o = ord_o * 8 + int'(req_ch) + 1;
        nib = 4'(nib_tab[req_ch]);
      end
      if (sample) begin got = 1'b1; lat = n; end
    end
    for (int v = 0; v < CH; v++) if (m_act[v]) model_voice(v, nib_tab[v]);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_req_order"}, ord_o, ord_e);
    check({tag, "_active"}, active, m_act);
    check({tag, "_sound"}, sound, model_mix());
  endtask

  initial begin
    int n, pulses;
    bit seen;

    // reset state
    do_reset();
    check("rst_req", req, 0);
    check("rst_sample", sample, 0);
    check("rst_sound", sound, 0);
    check("rst_active", active, 0);

    // single voice, nibble 0
    for (int v = 0; v < CH; v++) nib_tab[v] = 0;
    pulse(4'b0001, 4'b0000);
    do_round("first");
    check("first_sound_const", sound, 2);

    // positive clamp with nibble 7
    do_reset();
    nib_tab[0] = 7;
    pulse(4'b0001, 4'b0000);
    for (int r = 0; r < 12; r++) do_round("pos7");
    check("pos_clamp_const", sound, 2047);

    // two voices driven to the negative limit
    do_reset();
    nib_tab[0] = 15; nib_tab[1] = 15;
    pulse(4'b0011, 4'b0000);
    for (int r = 0; r < 20; r++) do_round("negF");
`ifdef JT6295_MC_SAT_EN
    check("neg_clamp_const", sound, -2048);
`else
    check("neg_clamp_const", sound, -4096);
`endif

    // attenuation
    do_reset();
    for (int v = 0; v < CH; v++) nib_tab[v] = 0;
    set_att(0, 2);
    nib_tab[0] = 7;
    pulse(4'b0001, 4'b0000);
    do_round("att2");
    check("att2_const", sound, 7);
    set_att(0, 15);
    nib_tab[0] = 15;
    do_round("att15");
    check("att15_const", sound, -1);

    // nibble stall
    do_reset();
    for (int v = 0; v < CH; v++) nib_tab[v] = 0;
    nib_tab[0] = 7;
    pulse(4'b0001, 4'b0000);
    do_round("pre_stall");
    nib_ok = 1'b0;
    model_round_start();
    cen = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      cen = 1'b0;
      if (req) seen = 1'b1;
    end
    check("stall_req_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cen = (i == 3 || i == 6);
      check("stall_req", req, 1);
      check("stall_req_ch", req_ch, 0);
    end
    cen = 1'b0;
    check("stall_sound_hold", sound, 30);
    nib = 4'd7; nib_ok = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (sample) seen = 1'b1;
    end
    model_voice(0, 7);
    check("stall_done", seen, 1);
    check("stall_sound", sound, model_mix());
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (sample) pulses++;
    end
    check("stall_no_second_round", pulses, 0);

    // start and stop together, then stop alone
    do_reset();
    for (int v = 0; v < CH; v++) nib_tab[v] = 0;
    pulse(4'b0100, 4'b0100);
    do_round("ss_same");
    check("ss_active_const", active, 4'b0100);
    check("ss_sound_const", sound, 2);
    pulse(4'b0000, 4'b0100);
    do_round("stop2");
    check("stop2_active_const", active, 0);

    // randomized rounds
    do_reset();
    pulse(4'b1111, 4'b0000);
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0)
        pulse(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 0)
        set_att(int'($urandom_range(0, CH - 1)),
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)));
      for (int v = 0; v < CH; v++) nib_tab[v] = int'($urandom_range(0, 15));
      do_round("rand");
    end

    // asynchronous reset in the middle of a request
    do_reset();
    for (int v = 0; v < CH; v++) nib_tab[v] = 0;
    nib_tab[0] = 7;
    pulse(4'b0001, 4'b0000);
    do_round("pre_abort");
    nib_ok = 1'b0;
    cen = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      cen = 1'b0;
      if (req) seen = 1'b1;
    end
    check("abort_req_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_req", req, 0);
    check("abort_sound", sound, 0);
    check("abort_active", active, 0);
    check("abort_sample", sample, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; nib_ok = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
